// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame-grab sequencer.
package cam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_FV,
    S_CAPTURE,
    S_RD,
    S_LOAD,
    S_TXWAIT
  } cam_state_e;

  localparam logic [7:0] CMD_CAPTURE_DEF = 8'hAA;
  localparam logic [7:0] CMD_ABORT_DEF   = 8'h1B;

  function automatic logic [7:0] pix_byte(
    input logic [9:0] pix
  );
    return pix[9:2];
  endfunction

endpackage

// File: rtl/cam_line_counter.sv
// Column/row tracking and write gating for one captured frame.
module cam_line_counter
  import cam_pkg::*;
#(
  parameter int IMG_W = 2,
  parameter int IMG_H = 3,
  localparam int CW = $clog2(IMG_W + 1),
  localparam int RW = $clog2(IMG_H + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          fv_i,
  input  logic          lv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          we_o,
  output logic          lv_fall_o,
  output logic          fv_fall_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);

  logic          lv_q, fv_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          row_adv;

  assign lv_fall_o = lv_q & ~lv_i;
  assign fv_fall_o = fv_q & ~fv_i;

  assign we_o = en_i & fv_i & lv_i
              & (col_q < COL_MAX)
              & (row_q < ROW_MAX);

  // Only lines that stored something advance the row.
  assign row_adv = en_i & lv_fall_o
                 & (col_q != '0)
                 & (row_q < ROW_MAX);

  assign col_o = col_q;
  assign row_o = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    unique case (1'b1)
      clr_i: begin
        col_d = '0;
        row_d = '0;
      end
      we_o: col_d = col_q + 1'b1;
      row_adv: begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Edge flops reset high so a mid-frame reset release is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lv_q  <= 1'b1;
      fv_q  <= 1'b1;
      col_q <= '0;
      row_q <= '0;
    end else begin
      lv_q  <= lv_i;
      fv_q  <= fv_i;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Frame-grab controller: arm on command, capture one frame into the
// pixel buffer, then stream it out over the UART transmitter.
module capture_sequencer
  import cam_pkg::*;
#(
  parameter int          IMG_W       = 2,
  parameter int          IMG_H       = 3,
  parameter logic [7:0]  CMD_CAPTURE = CMD_CAPTURE_DEF,
  parameter logic [7:0]  CMD_ABORT   = CMD_ABORT_DEF,
  localparam int NPIX = IMG_W * IMG_H,
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    CMD_DATA,
  input  logic          CMD_VALID,
  input  logic          CAM_FRAME_VALID,
  input  logic          CAM_LINE_VALID,
  input  logic [9:0]    CAM_DATA,
  output logic          BUF_WE,
  output logic [AW-1:0] BUF_ADDR,
  output logic [7:0]    BUF_WDATA,
  input  logic [7:0]    BUF_RDATA,
  output logic [7:0]    TX_DATA,
  output logic          TX_START,
  input  logic          TX_BUSY,
  output logic          BUSY,
  output logic          FRAME_DONE,
  output logic          ERR
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int NW = $clog2(NPIX + 1);
  localparam logic [NW-1:0] N_ALL  = NW'(NPIX);
  localparam logic [NW-1:0] N_LAST = NW'(NPIX - 1);

  cam_state_e    state_q, state_d;
  logic [NW-1:0] addr_q, addr_d;
  logic [7:0]    txd_q, txd_d;
  logic          start_q, start_d;
  logic          first_q, first_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          we, lv_fall, fv_fall;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          cmd_cap, cmd_abort;
  logic          unused_ok;

  cam_line_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_lines (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .clr_i     (state_q == S_WAIT_FV),
    .en_i      (state_q == S_CAPTURE),
    .fv_i      (CAM_FRAME_VALID),
    .lv_i      (CAM_LINE_VALID),
    .col_o     (col),
    .row_o     (row),
    .we_o      (we),
    .lv_fall_o (lv_fall),
    .fv_fall_o (fv_fall)
  );

  assign unused_ok = ^{col, row, lv_fall, CAM_DATA[1:0]};

  assign cmd_cap   = CMD_VALID & (CMD_DATA == CMD_CAPTURE);
  assign cmd_abort = CMD_VALID & (CMD_DATA == CMD_ABORT);

  assign BUF_WE     = we;
  assign BUF_ADDR   = addr_q[AW-1:0];
  assign BUF_WDATA  = pix_byte(CAM_DATA);
  assign TX_DATA    = txd_q;
  assign TX_START   = start_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = done_q;
  assign ERR        = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    txd_d   = txd_q;
    start_d = 1'b0;
    first_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (cmd_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (cmd_cap) state_d = S_ARM;
        S_ARM:
          if (!CAM_FRAME_VALID) state_d = S_WAIT_FV;
        S_WAIT_FV: begin
          addr_d = '0;
          if (CAM_FRAME_VALID) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (we) addr_d = addr_q + 1'b1;
          if (fv_fall) begin
            if (addr_q == N_ALL) begin
              addr_d  = '0;
              state_d = S_RD;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_RD:
          state_d = S_LOAD;
        S_LOAD:
          if (!TX_BUSY) begin
            txd_d   = BUF_RDATA;
            start_d = 1'b1;
            first_d = 1'b1;
            state_d = S_TXWAIT;
          end
        // First cycle is skipped: busy only rises after the start is taken.
        S_TXWAIT:
          if (!first_q && !TX_BUSY) begin
            if (addr_q == N_LAST) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_RD;
            end
          end
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      txd_q   <= '0;
      start_q <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      txd_q   <= txd_d;
      start_q <= start_d;
      first_q <= first_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with buffer and UART models.
module tb_capture_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] CMD_DATA = '0;
  logic       CMD_VALID = 1'b0;
  logic       CAM_FRAME_VALID = 1'b0;
  logic       CAM_LINE_VALID = 1'b0;
  logic [9:0] CAM_DATA = '0;
  logic       BUF_WE;
  logic [2:0] BUF_ADDR;
  logic [7:0] BUF_WDATA;
  logic [7:0] BUF_RDATA = '0;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       TX_BUSY = 1'b0;
  logic       BUSY;
  logic       FRAME_DONE;
  logic       ERR;

  capture_sequencer dut (
    .CLK             (CLK),
    .RST             (RST),
    .CMD_DATA        (CMD_DATA),
    .CMD_VALID       (CMD_VALID),
    .CAM_FRAME_VALID (CAM_FRAME_VALID),
    .CAM_LINE_VALID  (CAM_LINE_VALID),
    .CAM_DATA        (CAM_DATA),
    .BUF_WE          (BUF_WE),
    .BUF_ADDR        (BUF_ADDR),
    .BUF_WDATA       (BUF_WDATA),
    .BUF_RDATA       (BUF_RDATA),
    .TX_DATA         (TX_DATA),
    .TX_START        (TX_START),
    .TX_BUSY         (TX_BUSY),
    .BUSY            (BUSY),
    .FRAME_DONE      (FRAME_DONE),
    .ERR             (ERR)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [8];
  logic [7:0] tx_log [64];
  int wr_cnt = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int vecs = 0;
  int errs = 0;

  // Pixel buffer, UART transmitter and pulse monitors.
  always @(posedge CLK) begin
    if (BUF_WE) begin
      mem[BUF_ADDR] <= BUF_WDATA;
      wr_cnt <= wr_cnt + 1;
    end
    BUF_RDATA <= mem[BUF_ADDR];
    if (FRAME_DONE) done_cnt <= done_cnt + 1;
    if (ERR) err_cnt <= err_cnt + 1;
    if (TX_START && !TX_BUSY) begin
      tx_log[tx_cnt[5:0]] <= TX_DATA;
      tx_cnt <= tx_cnt + 1;
      TX_BUSY <= 1'b1;
      busy_cnt <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) TX_BUSY <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_px(input int base, input int i);
    return 32'(base + (i / 2 + 1) * 10 + (i % 2) + 1);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    CMD_DATA = b;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Ends with FV dropped at a negedge; caller handles what follows.
  task automatic frame(input int lines, input int ppl, input int base);
    logic [7:0] v;
    @(negedge CLK);
    CAM_FRAME_VALID = 1'b0;
    CAM_LINE_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    CAM_FRAME_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        v = 8'(base + (l + 1) * 10 + p + 1);
        CAM_LINE_VALID = 1'b1;
        CAM_DATA = {v, 2'b11};
        @(negedge CLK);
      end
      CAM_LINE_VALID = 1'b0;
      CAM_DATA = '0;
      repeat (2) @(negedge CLK);
    end
    CAM_FRAME_VALID = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 2000 && done_cnt == d0; i++)
      @(negedge CLK);
  endtask

  int w0, t0, d0, e0;
  bit sent;

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_we", BUF_WE, 0);
    chk("rst_start", TX_START, 0);
    chk("rst_addr", BUF_ADDR, 0);
    RST = 1'b1;
    @(negedge CLK);

    // Unknown command in IDLE does nothing.
    w0 = wr_cnt;
    send(8'h55);
    chk("cmd55_busy", BUSY, 0);
    frame(3, 2, 0);
    repeat (3) @(negedge CLK);
    chk("cmd55_wr", wr_cnt - w0, 0);
    chk("cmd55_busy2", BUSY, 0);

    // Command arrives mid-frame: that frame must be skipped.
    w0 = wr_cnt;
    t0 = tx_cnt;
    d0 = done_cnt;
    @(negedge CLK);
    CAM_FRAME_VALID = 1'b1;
    CAM_LINE_VALID = 1'b1;
    CAM_DATA = {8'hEE, 2'b11};
    repeat (3) @(negedge CLK);
    send(8'hAA);
    chk("arm_busy", BUSY, 1);
    repeat (4) @(negedge CLK);
    CAM_FRAME_VALID = 1'b0;
    CAM_LINE_VALID = 1'b0;
    @(negedge CLK);
    chk("skip_wr", wr_cnt - w0, 0);
    frame(3, 2, 0);

    // Stream, with a capture command injected mid-stream.
    sent = 0;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      if (!sent && tx_cnt == t0 + 3) begin
        CMD_DATA = 8'hAA;
        CMD_VALID = 1'b1;
        sent = 1;
      end
    end
    CMD_VALID = 1'b0;
    chk("cap_wr", wr_cnt - w0, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("cap_mem%0d", i), mem[i], exp_px(0, i));
    chk("done_cnt", done_cnt - d0, 1);
    chk("done_busy", BUSY, 0);
    chk("tx_cnt", tx_cnt - t0, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("tx%0d", i), tx_log[t0 + i], exp_px(0, i));
    repeat (20) @(negedge CLK);
    chk("done_once", done_cnt - d0, 1);
    chk("tx_after", tx_cnt - t0, 6);

    // Short frame: two lines only.
    t0 = tx_cnt;
    e0 = err_cnt;
    send(8'hAA);
    frame(2, 2, 0);
    @(negedge CLK);
    chk("short_err", ERR, 1);
    chk("short_idle", BUSY, 0);
    @(negedge CLK);
    chk("short_err_pulse", ERR, 0);
    repeat (20) @(negedge CLK);
    chk("short_err_cnt", err_cnt - e0, 1);
    chk("short_notx", tx_cnt - t0, 0);

    // Overlong frame: 4 pixels per line, 5 lines.
    w0 = wr_cnt;
    t0 = tx_cnt;
    d0 = done_cnt;
    send(8'hAA);
    frame(5, 4, 100);
    wait_done(d0);
    chk("long_wr", wr_cnt - w0, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("long_mem%0d", i), mem[i], exp_px(100, i));
    chk("long_done", done_cnt - d0, 1);
    chk("long_tx", tx_cnt - t0, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("long_tx%0d", i), tx_log[t0 + i], exp_px(100, i));
    repeat (15) @(negedge CLK);

    // Abort during capture.
    t0 = tx_cnt;
    e0 = err_cnt;
    send(8'hAA);
    @(negedge CLK);
    CAM_FRAME_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    CAM_LINE_VALID = 1'b1;
    CAM_DATA = {8'd77, 2'b11};
    @(negedge CLK);
    chk("abort_cap", BUSY, 1);
    CMD_DATA = 8'h1B;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("abort_idle", BUSY, 0);
    chk("abort_we", BUF_WE, 0);
    repeat (3) @(negedge CLK);
    CAM_LINE_VALID = 1'b0;
    CAM_FRAME_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    chk("abort_noerr", err_cnt - e0, 0);
    chk("abort_notx", tx_cnt - t0, 0);

    // Asynchronous reset while waiting on the transmitter.
    t0 = tx_cnt;
    send(8'hAA);
    frame(3, 2, 0);
    for (int i = 0; i < 200 && tx_cnt == t0; i++)
      @(negedge CLK);
    repeat (3) @(negedge CLK);
    chk("txw_busy", BUSY, 1);
    chk("txw_data", TX_DATA, 11);
    #2 RST = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_txd", TX_DATA, 0);
    chk("arst_addr", BUF_ADDR, 0);
    chk("arst_strobes", {BUF_WE, TX_START, FRAME_DONE, ERR}, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    chk("arst_idle", BUSY, 0);
    chk("arst_tx", tx_cnt - t0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
